// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: ALU control codes and default widths shared by the ALU control decoder and the EX stage
package alu_exec_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int TAG_W_DEF = 5;
   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_ctrl_e;
endpackage

// File: rtl/alu_exec_stage_core.sv
// alu_core: combinational MIPS ALU producing result, signed overflow and illegal-code flags
module alu_core
   import alu_exec_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             illegal
);
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   assign sum  = a + b;
   assign diff = a - b;
   // decode the control code; unknown codes yield zero with illegal set
   always_comb begin
      result   = '0;
      overflow = 1'b0;
      illegal  = 1'b0;
      case (alu_ctrl_e'(control))
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: begin
            result   = sum;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            result   = diff;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_NOR: result = ~(a | b);
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: EX-stage ALU with a 2-entry (main + skid) elastic output buffer and flush
module alu_exec_stage
   import alu_exec_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal,
   output logic [TAG_W-1:0] tag_out
);
   localparam int EW = WIDTH + TAG_W + 2;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic             alu_ill;
   logic [EW-1:0]    new_e;
   logic [EW-1:0]    main_q, main_d, skid_q, skid_d;
   logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic             acc;
   logic             main_free;
   alu_core #(.WIDTH(WIDTH)) u_core (
      .control (control),
      .a       (op_a),
      .b       (op_b),
      .result  (alu_res),
      .overflow(alu_ovf),
      .illegal (alu_ill)
   );
   assign new_e     = {alu_res, alu_ovf, alu_ill, tag_in};
   assign in_ready  = !skid_v_q;
   assign acc       = in_valid && in_ready;
   assign main_free = !main_v_q || out_ready;
   assign out_valid = main_v_q;
   assign {result, overflow, illegal, tag_out} = main_q;
   assign zero      = main_v_q && (result == '0);
   // buffer steering: flush wins, then drain skid into main, then fill main or skid
   always_comb begin
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      main_d   = main_q;
      skid_d   = skid_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (main_free && skid_v_q) begin
         main_d   = skid_q;
         main_v_d = 1'b1;
         skid_v_d = acc;
         skid_d   = acc ? new_e : skid_q;
      end else if (main_free) begin
         main_v_d = acc;
         main_d   = acc ? new_e : main_q;
      end else if (acc) begin
         skid_v_d = 1'b1;
         skid_d   = new_e;
      end
   end
   // state registers, cleared asynchronously so nothing survives a reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         main_q   <= '0;
         skid_q   <= '0;
      end else begin
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         main_q   <= main_d;
         skid_q   <= skid_d;
      end
   end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- EX-stage execution unit of the pipelined MIPS datapath.
- Consumes the 4-bit ALU control code produced by the ALU control decoder, plus two operands and a destination-register tag.
- Computes the result and registers it into a 2-entry elastic output (main register + skid register) with valid/ready handshakes on both sides.
- Feeds the EX/MEM boundary. Supports pipeline flush on branch mispredict.

Parameters:
- WIDTH, 32, operand/result width in bits.
- TAG_W, 5, destination register tag width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all buffered and incoming work.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage can accept an operation this cycle.
- control  input  4  ALU control code.
- op_a  input  WIDTH  operand A (rs).
- op_b  input  WIDTH  operand B (rt or sign-extended immediate).
- tag_in  input  TAG_W  destination register number.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  ALU result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (ADD/SUB only).
- illegal  output  1  unsupported control code.
- tag_out  output  TAG_W  tag travelling with the result.

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted:
  - main and skid valid bits = 0; all data registers = 0.
  - out_valid=0, result=0, zero=0, overflow=0, illegal=0, tag_out=0.
  - in_ready=1 the first cycle after deassertion.
- Operations (combinational compute, registered output):
  - 0000 AND: a & b
  - 0001 OR: a | b
  - 0010 ADD: a + b, modulo 2^WIDTH
  - 0110 SUB: a - b, modulo 2^WIDTH
  - 0111 SLT: signed compare; 1 if a<b else 0, zero-extended
  - 1100 NOR: ~(a | b)
  - any other code: result=0, illegal=1, overflow=0
- overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from a.
  - All other ops: overflow=0.
- zero is computed from the stored result, so it is always consistent with the presented result.
- Latency: an operation accepted in cycle N appears on the outputs in cycle N+1 if the main register is empty or draining.
- Handshakes:
  - Input transfer happens when in_valid & in_ready.
  - Output transfer happens when out_valid & out_ready.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- Buffering:
  - in_ready = !skid_valid; this is a registered signal with no combinational path from out_ready.
  - If the main register is empty, or it transfers this cycle, the accepted op goes to main (or skid content moves to main first, then the new op goes to skid).
  - If main is stalled (valid, not ready), the accepted op goes to skid.
  - When main transfers and skid is valid: skid moves to main. A new accept in the same cycle then fills skid.
  - Full throughput: one op per cycle when out_ready is held at 1.
  - Order preserved: FIFO, depth 2.
- Flush:
  - On the next edge, both valid bits are cleared. Any same-cycle input transfer is discarded.
  - Flush has priority over accept and over output transfer.
  - Data registers may keep stale values; outputs are qualified by out_valid only.
  - in_ready=1 the cycle after a flush.
- Simultaneous accept + output transfer with skid empty: main is replaced by the new op and stays valid.
- Reset asserted mid-transfer: the operation is lost; no partial state survives.

Decomposition:
- Shared package/header holds:
  - ALU control code constants (AND, OR, ADD, SUB, SLT, NOR), used by both the ALU control decoder and this block.
  - WIDTH default.
- One sub-module, alu_core: purely combinational, inputs (control, a, b), outputs (result, overflow, illegal).
- alu_exec_stage instantiates alu_core and implements the 2-entry elastic buffer.

Test Plan:
- Reset mid-stream: assert reset with both entries full -> immediately out_valid=0, result=0, tag_out=0. After release, in_ready=1.
- Basic ops, out_ready=1:
  - ADD 5+7 -> 12, zero=0 one cycle later.
  - SUB 9-9 -> 0, zero=1.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - NOR 0,0 -> 0xFFFFFFFF.
  - control 0101 -> result 0, illegal=1.
- Overflow:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
  - SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
  - AND of the same operands -> overflow=0.
- Backpressure: hold out_ready=0 and send 3 ops (tags 1, 2, 3) -> accepts tags 1 and 2, then in_ready=0. Release out_ready -> tags emerge in order 1, 2, 3 with no loss or duplication; result held stable during the stall.
- Throughput: 16 back-to-back ADDs with out_ready=1 -> 16 results on 16 consecutive cycles.
- Flush: two entries buffered plus in_valid=1 with flush=1 -> next cycle out_valid=0, in_ready=1; the flushed tags never appear on the output.
